wtime_calc: RTL

- Produces the 5-bit customer wait time `wtime` for the bank queue-management system. The existing wait-time 7-segment decoder consumes this value.
- Tracks the queue population from the entry (back) and exit (front) photocell sensors.
- Computes wtime = floor(3*(pcount + tcount - 1) / tcount) with a multi-cycle restoring divider.
- Presents `wtime` as a held register with a completion pulse.

---
 rtl/wtime_calc.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wtime_calc.sv
// Queue population tracker and wait-time calculator for the bank queue system.
// wtime = floor(TSVC*(pcount+tcount-1)/tcount), computed by a 5-step restoring divider.
module wtime_calc #(
  parameter int PMAX = 7,
  parameter int TSVC = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       back_sensor,
  input  logic       front_sensor,
  input  logic [1:0] tcount,
  output logic [2:0] pcount,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic [4:0] wtime,
  output logic       wtime_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Numerator TSVC*(p+t-1), truncated to 5 bits; the p==0,t==0 wrap is overridden in DONE.
  function automatic logic [4:0] numer(input logic [2:0] p, input logic [1:0] t);
    logic [3:0] s;
    s = {1'b0, p} + {2'b00, t} - 4'd1;
    return 5'(TSVC) * {1'b0, s};
  endfunction

  logic [1:0] back_sync_r;
  logic [1:0] front_sync_r;
  logic       back_prev_r;
  logic       front_prev_r;
  logic       join_s;
  logic       leave_s;

  logic [2:0] pcount_r;
  logic [2:0] pcount_nxt_s;
  logic       full_r;
  logic       empty_r;
  logic [1:0] tcount_q_r;
  logic       chg_s;
  logic       dirty_r;

  state_t     state_r;
  state_t     state_nxt_s;
  logic       load_s;
  logic       div_s;
  logic       done_s;
  logic       clr_dirty_s;

  logic [2:0] p_r;
  logic [1:0] t_r;
  logic [4:0] num_r;
  logic [1:0] rem_r;
  logic [4:0] quo_r;
  logic [2:0] iter_r;
  logic [2:0] rem_sh_s;
  logic [1:0] rem_nxt_s;
  logic       qbit_s;
  logic [4:0] result_s;

  logic       busy_r;
  logic [4:0] wtime_r;
  logic       wtime_valid_r;

  // Two-flop synchronizers plus previous-value registers for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      back_sync_r  <= 2'b00;
      front_sync_r <= 2'b00;
      back_prev_r  <= 1'b0;
      front_prev_r <= 1'b0;
    end else begin
      back_sync_r  <= {back_sync_r[0], back_sensor};
      front_sync_r <= {front_sync_r[0], front_sensor};
      back_prev_r  <= back_sync_r[1];
      front_prev_r <= front_sync_r[1];
    end
  end

  assign join_s  = back_sync_r[1] & ~back_prev_r;
  assign leave_s = front_sync_r[1] & ~front_prev_r;

  // Next population: a simultaneous join and leave cancels even at the limits.
  always_comb begin
    pcount_nxt_s = pcount_r;
    if (join_s && !leave_s && !full_r) begin
      pcount_nxt_s = pcount_r + 3'd1;
    end else if (leave_s && !join_s && !empty_r) begin
      pcount_nxt_s = pcount_r - 3'd1;
    end else begin
      pcount_nxt_s = pcount_r;
    end
  end

  assign chg_s = (pcount_nxt_s != pcount_r) || (tcount != tcount_q_r);

  // Population counter, status flags, registered teller count and pending-recompute flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcount_r   <= 3'd0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      tcount_q_r <= 2'd0;
      dirty_r    <= 1'b0;
    end else begin
      pcount_r   <= pcount_nxt_s;
      full_r     <= (pcount_nxt_s == 3'(PMAX));
      empty_r    <= (pcount_nxt_s == 3'd0);
      tcount_q_r <= tcount;
      if (chg_s) begin
        dirty_r <= 1'b1;
      end else if (clr_dirty_s) begin
        dirty_r <= 1'b0;
      end else begin
        dirty_r <= dirty_r;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (dirty_r) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: state_nxt_s = DIV;
      DIV: begin
        if (iter_r == 3'd1) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DIV;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode: datapath strobes.
  always_comb begin
    load_s      = 1'b0;
    div_s       = 1'b0;
    done_s      = 1'b0;
    clr_dirty_s = 1'b0;
    case (state_r)
      IDLE:    clr_dirty_s = dirty_r;
      LOAD:    load_s      = 1'b1;
      DIV:     div_s       = 1'b1;
      DONE:    done_s      = 1'b1;
      default: clr_dirty_s = 1'b0;
    endcase
  end

  // One restoring-division step: remainder stays below T, so two bits hold it.
  always_comb begin
    rem_sh_s = {rem_r, num_r[4]};
    if (rem_sh_s >= {1'b0, t_r}) begin
      rem_nxt_s = 2'(rem_sh_s - {1'b0, t_r});
      qbit_s    = 1'b1;
    end else begin
      rem_nxt_s = rem_sh_s[1:0];
      qbit_s    = 1'b0;
    end
  end

  // Special cases take priority over the quotient.
  always_comb begin
    if (p_r == 3'd0) begin
      result_s = 5'd0;
    end else if (t_r == 2'd0) begin
      result_s = 5'd31;
    end else begin
      result_s = quo_r;
    end
  end

  // Divider datapath: operands latched in LOAD, one quotient bit per DIV cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_r    <= 3'd0;
      t_r    <= 2'd0;
      num_r  <= 5'd0;
      rem_r  <= 2'd0;
      quo_r  <= 5'd0;
      iter_r <= 3'd0;
    end else if (load_s) begin
      p_r    <= pcount_r;
      t_r    <= tcount_q_r;
      num_r  <= numer(pcount_r, tcount_q_r);
      rem_r  <= 2'd0;
      quo_r  <= 5'd0;
      iter_r <= 3'd5;
    end else if (div_s) begin
      num_r  <= {num_r[3:0], 1'b0};
      rem_r  <= rem_nxt_s;
      quo_r  <= {quo_r[3:0], qbit_s};
      iter_r <= iter_r - 3'd1;
    end else begin
      p_r    <= p_r;
      t_r    <= t_r;
      num_r  <= num_r;
      rem_r  <= rem_r;
      quo_r  <= quo_r;
      iter_r <= iter_r;
    end
  end

  // Registered result, completion pulse and busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wtime_r       <= 5'd0;
      wtime_valid_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      busy_r        <= (state_nxt_s != IDLE);
      wtime_valid_r <= done_s;
      if (done_s) begin
        wtime_r <= result_s;
      end else begin
        wtime_r <= wtime_r;
      end
    end
  end

  assign pcount      = pcount_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign busy        = busy_r;
  assign wtime       = wtime_r;
  assign wtime_valid = wtime_valid_r;

endmodule
